// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the default geometry of the receive FIFO and the receive byte width.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned RX_FIFO_DEPTH   = 8;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO.
// Ports:
//   clk   - write clock
//   we    - write enable; stores wdata at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - asynchronous read data at raddr
// Contents are never reset. The FIFO control logic hides stale data.
module uart_fifo_mem #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read port. This supports show-ahead at the FIFO head.
  assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO that sits between the UART receiver and the
// memory-map controller.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   wr_en    - push strobe; wr_data / wr_perr are the byte and its parity flag
//   rd_en    - pop strobe
//   clr_ovf  - clears the sticky overflow flag
//   rd_data  - head-entry byte; 0 when empty
//   rd_perr  - head-entry parity flag; 0 when empty
//   empty    - no entries are stored
//   full     - DEPTH entries are stored
//   count    - number of stored entries
//   overflow - sticky flag; set when a byte is dropped
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = RX_FIFO_DEPTH,
  localparam int unsigned PW        = $clog2(DEPTH),
  localparam int unsigned CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_perr,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_perr,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count,
  output logic                  overflow
);

  localparam int unsigned EW = DATA_WIDTH + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push_c, pop_c, drop_c;
  logic [EW-1:0] head_c;

  assign empty    = (count_q == CW'(0));
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = ovf_q;

  // Pointer, occupancy and overflow next-state logic.
  always_comb begin
    pop_c    = 1'b0;
    push_c   = 1'b0;
    drop_c   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    pop_c  = rd_en && !empty;
    // When the FIFO is full, a simultaneous pop frees the slot,
    // because DEPTH >= 2 means full implies not empty.
    push_c = wr_en && (!full || rd_en);
    drop_c = wr_en && full && !rd_en;

    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // If a set and a clear arrive together, the set wins.
    if (drop_c)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_c && !rst),
    .waddr (wr_ptr_q),
    .wdata ({wr_perr, wr_data}),
    .raddr (rd_ptr_q),
    .rdata (head_c)
  );

  // Mask the head entry while empty so stale storage stays invisible.
  assign rd_data = empty ? '0   : head_c[DATA_WIDTH-1:0];
  assign rd_perr = empty ? 1'b0 : head_c[DATA_WIDTH];

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. It uses a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned DW    = UART_DATA_WIDTH;
  localparam int unsigned DEPTH = RX_FIFO_DEPTH;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_perr = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_perr;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  int vectors = 0;
  int errors  = 0;

  // Reference model: the stored entries are {perr, data}, oldest first.
  logic [DW:0] mq[$];
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_perr  (wr_perr),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .rd_perr  (rd_perr),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [DW:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    check("count",    32'(count),    32'(mq.size()));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("full",     32'(full),     32'(mq.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("rd_data",  32'(rd_data),  32'(head[DW-1:0]));
    check("rd_perr",  32'(rd_perr),  32'(head[DW]));
  endtask

  // Drive one clock of stimulus, advance the model by the stated rules,
  // and then compare every output.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic p,
                      input logic r, input logic c, input logic rs);
    bit was_full, was_empty, popped;
    wr_en = w; wr_data = d; wr_perr = p; rd_en = r; clr_ovf = c; rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      popped    = r && !was_empty;
      if (popped) void'(mq.pop_front());
      if (w && (!was_full || popped)) mq.push_back({p, d});
      if (w && was_full && !r) m_ovf = 1'b1;
      else if (c)              m_ovf = 1'b0;
    end
    wr_en = 1'b0; wr_data = '0; wr_perr = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
    check_all();
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] exp35 [8];
    exp35[0] = 8'h04; exp35[1] = 8'h05; exp35[2] = 8'h06; exp35[3] = 8'h07;
    exp35[4] = 8'h08; exp35[5] = 8'hA0; exp35[6] = 8'hA1; exp35[7] = 8'hA2;

    // Reset state.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_empty", 32'(empty), 32'd1);

    // A single push, then a single pop.
    push(8'h41);
    check("r33_data", 32'(rd_data), 32'h41);
    pop();
    check("r33_data0", 32'(rd_data), 32'h0);

    // Fill the FIFO, overflow it, then drain it in order.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    check("r34_full", 32'(full), 32'd1);
    push(8'h09);
    check("r34_ovf", 32'(overflow), 32'd1);
    check("r34_cnt", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check("r34_order", 32'(rd_data), 32'(i));
      pop();
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Wraparound.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int i = 0; i < 3; i++) pop();
    for (int i = 0; i < 3; i++) push(DW'(8'hA0 + i));
    for (int i = 0; i < 8; i++) begin
      check("r35_order", 32'(rd_data), 32'(exp35[i]));
      pop();
    end

    // Simultaneous push and pop while full, and while empty.
    for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    check("r36_cnt8", 32'(count), 32'd8);
    check("r36_noovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop();
    step(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
    check("r36_cnt1", 32'(count), 32'd1);
    check("r36_data", 32'(rd_data), 32'h66);
    pop();

    // Parity flag at the head; a set on overflow beats a clear.
    step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    check("r37_perr", 32'(rd_perr), 32'd1);
    pop();
    for (int i = 0; i < 8; i++) push(DW'(i));
    push(8'hEE);
    step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
    check("r37_setwins", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset dominates a push in the same cycle.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push(DW'(8'hC0 + i));
    step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1);
    check("r38_cnt", 32'(count), 32'd0);
    check("r38_empty", 32'(empty), 32'd1);

    // Randomized traffic. Each phase biases the FIFO toward full or empty.
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 75 : 30;
      rp = (ph % 2 == 0) ? 30 : 70;
      for (int n = 0; n < 400; n++) begin
        step(1'($urandom_range(0, 99) < wp),
             DW'($urandom()),
             1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 99) < rp),
             1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 299) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
